sdram_read: RTL

Read-side engine of the SDRAM controller, and the counterpart to the write engine.
- On a trigger, it obtains the SDRAM bus from the arbiter and streams rows 0..ROW_LAST of one bank using BL=4 READ bursts.
- It yields the bus for auto-refresh at burst boundaries, then resumes where it stopped.
- It captures returned data after the CAS latency and presents it as a valid-qualified word stream.

---
 rtl/sdram_pkg.sv | 30 +++
 rtl/sdram_rd_capture.sv | 66 ++++++
 rtl/sdram_read.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command codes, one-hot read-engine states, geometry
// constants and the write engine's burst test pattern.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned COL_W     = 9;
  localparam int unsigned ROW_W     = 12;

  localparam logic [11:0] PRE_ALL_ADDR = 12'h400;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ACT  = 5'b00100,
    S_RD   = 5'b01000,
    S_PRE  = 5'b10000
  } state_t;

  // Beats 0..3 of every burst carry 3, 5, 7, 9.
  function automatic logic [15:0] rd_pattern(input logic [1:0] beat);
    return 16'd3 + {13'd0, beat, 1'b0};
  endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture: CAS-latency valid pipeline, rd_dq sample register and,
// with SDRAM_RD_CHECK_EN defined, the burst pattern checker (sticky error).
module sdram_rd_capture
  import sdram_pkg::*;
#(
  parameter int unsigned CAS_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_issue,
  input  logic [15:0] i_dq,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_err
);

  localparam int unsigned PIPE_W = CAS_LAT + 3;

  logic [PIPE_W-1:0] r_pipe;
  logic [15:0]       r_data;
  logic              r_valid;
  logic              w_sample;

  // A READ in cycle t keeps this window lit for cycles t+CAS_LAT .. t+CAS_LAT+3.
  assign w_sample = |r_pipe[PIPE_W-1:CAS_LAT-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pipe  <= {r_pipe[PIPE_W-2:0], i_rd_issue};
      r_valid <= w_sample;
      if (w_sample) r_data <= i_dq;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

`ifdef SDRAM_RD_CHECK_EN
  logic [1:0] r_beat;
  logic [1:0] r_beat_q;
  logic       r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat   <= '0;
      r_beat_q <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_sample) begin
        r_beat   <= r_beat + 1'b1;
        r_beat_q <= r_beat;
      end
      if (r_valid && (r_data != rd_pattern(r_beat_q))) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: rtl/sdram_read.sv
// sdram_read: read engine; arbitrated ACT/READ/PRE sequencing over rows 0..ROW_LAST
// of one bank with refresh yield. SDRAM_RD_CHECK_EN enables the data pattern checker.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int unsigned CAS_LAT  = 3,
  parameter int unsigned TRCD     = 2,
  parameter int unsigned TRP      = 2,
  parameter int unsigned ROW_LAST = 1,
  parameter logic [1:0]  BANK     = 2'd0
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        rd_trig,
  output logic        rd_req,
  input  logic        rd_en,
  input  logic        ref_req,
  output logic        flag_rd_end,
  output logic [3:0]  rd_cmd,
  output logic [11:0] rd_addr,
  output logic [1:0]  bank_addr,
  input  logic [15:0] rd_dq,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err
);

  localparam int unsigned CNT_W = 4;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_ref_pend;
  logic [3:0]       r_cmd, w_cmd_nxt;
  logic [11:0]      r_addr, w_addr_nxt;
  logic             r_flag, w_flag_nxt;
  logic             w_ref, w_row_end, w_done, w_slot_end, w_pre_end;

  // The column pointer advances right after each READ, so a zero column while
  // reading means the row's last burst has gone out.
  assign w_ref      = ref_req | r_ref_pend;
  assign w_row_end  = (r_col == '0);
  assign w_done     = w_row_end && (r_row == ROW_W'(ROW_LAST + 1));
  assign w_slot_end = (r_state == S_RD) && (r_cnt[1:0] == 2'd3);
  assign w_pre_end  = (r_state == S_PRE) && (r_cnt == CNT_W'(TRP - 1));

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (rd_trig) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_cnt_nxt = '0;
        if (rd_en) w_state_nxt = S_ACT;
      end
      S_ACT: begin
        if (r_cnt == CNT_W'(TRCD - 1)) begin
          w_state_nxt = S_RD;
          w_cnt_nxt   = '0;
        end
      end
      S_RD: begin
        if (w_slot_end) begin
          w_cnt_nxt = '0;
          if (w_done || w_row_end || w_ref) w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        if (w_pre_end) begin
          w_cnt_nxt = '0;
          if (w_done)     w_state_nxt = S_IDLE;
          else if (w_ref) w_state_nxt = S_REQ;
          else            w_state_nxt = S_ACT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Command/address are registered from the upcoming state so they line up with it.
  always_comb begin
    w_cmd_nxt  = CMD_NOP;
    w_addr_nxt = r_addr;
    w_flag_nxt = w_pre_end && (w_done || w_ref);
    if (w_cnt_nxt == '0) begin
      if (w_state_nxt == S_ACT) begin
        w_cmd_nxt  = CMD_ACT;
        w_addr_nxt = r_row;
      end else if (w_state_nxt == S_RD) begin
        w_cmd_nxt  = CMD_RD;
        w_addr_nxt = {3'b000, r_col[COL_W-1:2], 2'b00};
      end else if (w_state_nxt == S_PRE) begin
        w_cmd_nxt  = CMD_PRE;
        w_addr_nxt = PRE_ALL_ADDR;
      end
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_cmd  <= CMD_NOP;
      r_addr <= '0;
      r_flag <= 1'b0;
    end else begin
      r_cmd  <= w_cmd_nxt;
      r_addr <= w_addr_nxt;
      r_flag <= w_flag_nxt;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_row      <= '0;
      r_col      <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_cmd == CMD_RD) begin
        r_col <= r_col + COL_W'(BURST_LEN);
        if (r_col == COL_W'((1 << COL_W) - BURST_LEN)) r_row <= r_row + 1'b1;
      end
      if (w_pre_end) begin
        r_ref_pend <= 1'b0;
      end else if (ref_req && ((r_state == S_ACT) || (r_state == S_RD) ||
                               (r_state == S_PRE))) begin
        r_ref_pend <= 1'b1;
      end
    end
  end

  assign rd_req      = (r_state == S_REQ);
  assign flag_rd_end = r_flag;
  assign rd_cmd      = r_cmd;
  assign rd_addr     = r_addr;
  assign bank_addr   = BANK;

  sdram_rd_capture #(
    .CAS_LAT (CAS_LAT)
  ) u_capture (
    .i_clk      (sclk),
    .i_rst      (reset),
    .i_rd_issue (r_cmd == CMD_RD),
    .i_dq       (rd_dq),
    .o_data     (rd_data),
    .o_valid    (rd_valid),
    .o_err      (rd_err)
  );

endmodule
